// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with memory handshakes,
// wait timeouts, sticky trap and retired-instruction counter.
module mc_ctrl_fsm #(
    parameter int ALUOP_W = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               imem_ack,
    input  logic               dmem_ack,
    output logic               imem_req,
    output logic               dmem_req,
    output logic               mem_write,
    output logic               ir_write,
    output logic               pc_write,
    output logic               reg_write,
    output logic [ALUOP_W-1:0] aluop,
    output logic               s_ext,
    output logic               s_a,
    output logic               s_b,
    output logic [1:0]         s_num_write,
    output logic [1:0]         s_data_write,
    output logic [1:0]         s_npc,
    output logic [2:0]         state,
    output logic               trap,
    output logic [1:0]         trap_cause,
    output logic [CNT_W-1:0]   retire_cnt
);
    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
        S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd5
    } state_t;
    typedef enum logic [2:0] {C_ALU, C_JAL, C_LW, C_SW, C_BEQ, C_J, C_JR} cls_t;

    localparam logic [1:0] NUM_RT = 2'd0, NUM_RD = 2'd1, NUM_R31 = 2'd2;
    localparam logic [1:0] DW_ALU = 2'd0, DW_MEM = 2'd1, DW_NPC = 2'd2;
    localparam logic [1:0] N_NPC = 2'd0, BEQ_NPC = 2'd1, J_NPC = 2'd2, JR_NPC = 2'd3;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                           ALU_SLT = 4'd4, ALU_SLL = 4'd5, ALU_LUI = 4'd6;
    localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WLAST = WCNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t              state_q;
    cls_t                cls_q;
    logic [3:0]          alu_q;
    logic                ext_q, sa_q, sb_q;
    logic [1:0]          num_q, data_q, npc_q;
    logic [WCNT_W-1:0]   wcnt_q;
    logic                trap_q;
    logic [1:0]          cause_q;
    logic [CNT_W-1:0]    retire_q;

    logic       dec_legal, dec_ext, dec_a, dec_b;
    cls_t       dec_cls;
    logic [3:0] dec_alu;
    logic [1:0] dec_num, dec_data, dec_npc;
    logic       retire;
    logic       wait_expired;

    // Single-cycle decode table, captured into the latched selects during DECODE.
    always_comb begin
        dec_legal = 1'b1;
        dec_cls   = C_ALU;
        dec_alu   = ALU_ADD;
        dec_ext   = 1'b1;
        dec_a     = 1'b0;
        dec_b     = 1'b1;
        dec_num   = NUM_RT;
        dec_data  = DW_ALU;
        dec_npc   = N_NPC;
        case (op)
            6'h00: begin
                dec_b   = 1'b0;
                dec_num = NUM_RD;
                case (funct)
                    6'h20, 6'h21: dec_alu = ALU_ADD;
                    6'h23:        dec_alu = ALU_SUB;
                    6'h24:        dec_alu = ALU_AND;
                    6'h25:        dec_alu = ALU_OR;
                    6'h2A:        dec_alu = ALU_SLT;
                    6'h00: begin dec_alu = ALU_SLL; dec_a = 1'b1; end
                    6'h08: begin dec_cls = C_JR; dec_npc = JR_NPC; end
                    default:      dec_legal = 1'b0;
                endcase
            end
            6'h08, 6'h09: dec_alu = ALU_ADD;
            6'h0C: begin dec_alu = ALU_AND; dec_ext = 1'b0; end
            6'h0D: begin dec_alu = ALU_OR;  dec_ext = 1'b0; end
            6'h0F: begin dec_alu = ALU_LUI; dec_ext = 1'b0; end
            6'h23: begin dec_cls = C_LW; dec_data = DW_MEM; end
            6'h2B: dec_cls = C_SW;
            6'h02: begin dec_cls = C_J; dec_npc = J_NPC; end
            6'h03: begin
                dec_cls  = C_JAL;
                dec_npc  = J_NPC;
                dec_num  = NUM_R31;
                dec_data = DW_NPC;
            end
            6'h04: begin dec_cls = C_BEQ; dec_alu = ALU_SUB; dec_b = 1'b0; dec_npc = BEQ_NPC; end
            default: dec_legal = 1'b0;
        endcase
    end

    assign wait_expired = (TIMEOUT != 0) && (wcnt_q == WLAST);

    always_comb begin
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        retire    = 1'b0;
        s_npc     = npc_q;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_write = imem_ack;
                end
                S_EXEC: begin
                    if (cls_q == C_BEQ || cls_q == C_J || cls_q == C_JR) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end
                    if (cls_q == C_BEQ && !zero) s_npc = N_NPC;
                end
                S_MEM: begin
                    dmem_req  = 1'b1;
                    mem_write = (cls_q == C_SW);
                    if (dmem_ack && cls_q == C_SW) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    retire    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            cls_q    <= C_ALU;
            alu_q    <= '0;
            ext_q    <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            num_q    <= '0;
            data_q   <= '0;
            npc_q    <= '0;
            wcnt_q   <= '0;
            trap_q   <= 1'b0;
            cause_q  <= '0;
            retire_q <= '0;
        end else begin
            if (retire) retire_q <= retire_q + 1'b1;
            case (state_q)
                S_FETCH: begin
                    if (imem_ack) state_q <= S_DECODE;
                    else if (wait_expired) begin
                        state_q <= S_TRAP;
                        trap_q  <= 1'b1;
                        cause_q <= 2'b10;
                    end else wcnt_q <= wcnt_q + 1'b1;
                end
                S_DECODE: begin
                    if (dec_legal) begin
                        state_q <= S_EXEC;
                        cls_q   <= dec_cls;
                        alu_q   <= dec_alu;
                        ext_q   <= dec_ext;
                        sa_q    <= dec_a;
                        sb_q    <= dec_b;
                        num_q   <= dec_num;
                        data_q  <= dec_data;
                        npc_q   <= dec_npc;
                    end else begin
                        state_q <= S_TRAP;
                        trap_q  <= 1'b1;
                        cause_q <= 2'b01;
                    end
                end
                S_EXEC: begin
                    wcnt_q <= '0;
                    case (cls_q)
                        C_BEQ, C_J, C_JR: state_q <= S_FETCH;
                        C_LW, C_SW:       state_q <= S_MEM;
                        default:          state_q <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        wcnt_q  <= '0;
                        state_q <= (cls_q == C_SW) ? S_FETCH : S_WB;
                    end else if (wait_expired) begin
                        state_q <= S_TRAP;
                        trap_q  <= 1'b1;
                        cause_q <= 2'b11;
                    end else wcnt_q <= wcnt_q + 1'b1;
                end
                S_WB: begin
                    wcnt_q  <= '0;
                    state_q <= S_FETCH;
                end
                S_TRAP: ;
                default: begin
                    state_q <= S_TRAP;
                    trap_q  <= 1'b1;
                    cause_q <= 2'b01;
                end
            endcase
        end
    end

    assign aluop        = ALUOP_W'(alu_q);
    assign s_ext        = ext_q;
    assign s_a          = sa_q;
    assign s_b          = sb_q;
    assign s_num_write  = num_q;
    assign s_data_write = data_q;
    assign state        = state_q;
    assign trap         = trap_q;
    assign trap_cause   = cause_q;
    assign retire_cnt   = retire_q;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: instruction flows, traps, timeouts and strobes.
module tb_mc_ctrl_fsm;
    logic        clk = 1'b0;
    logic        rst, zero, imem_ack, dmem_ack;
    logic [5:0]  op, funct;
    logic        imem_req, dmem_req, mem_write, ir_write, pc_write, reg_write;
    logic [3:0]  aluop;
    logic        s_ext, s_a, s_b;
    logic [1:0]  s_num_write, s_data_write, s_npc;
    logic [2:0]  state;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [31:0] retire_cnt;

    int n_chk = 0;
    int n_fail = 0;

    mc_ctrl_fsm #(.ALUOP_W(4), .TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .mem_write(mem_write),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .aluop(aluop), .s_ext(s_ext), .s_a(s_a), .s_b(s_b),
        .s_num_write(s_num_write), .s_data_write(s_data_write), .s_npc(s_npc),
        .state(state), .trap(trap), .trap_cause(trap_cause), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs set afterwards apply to the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; op = 6'h00; funct = 6'h21; zero = 1'b0;
        imem_ack = 1'b1; dmem_ack = 1'b0;
        tick(); #1;
        chk("rst_state", state, 0);
        chk("rst_trap", trap, 0);
        chk("rst_retire", retire_cnt, 0);
        chk("rst_imem_req", imem_req, 0);

        // ADDU
        rst = 1'b0; #1;
        chk("addu_f_state", state, 0);
        chk("addu_f_ir_write", ir_write, 1);
        tick(); #1;
        chk("addu_d_state", state, 1);
        chk("addu_d_reg_write", reg_write, 0);
        tick(); #1;
        chk("addu_e_state", state, 2);
        chk("addu_e_aluop", aluop, 0);
        chk("addu_e_num", s_num_write, 1);
        chk("addu_e_reg_write", reg_write, 0);
        tick(); #1;
        chk("addu_wb_state", state, 4);
        chk("addu_wb_reg_write", reg_write, 1);
        chk("addu_wb_pc_write", pc_write, 1);
        chk("addu_wb_npc", s_npc, 0);
        tick(); #1;
        chk("addu_retire", retire_cnt, 1);

        // LW with dmem_ack on the 4th request cycle: F D E M M M M WB = 8 cycles
        op = 6'h23; #1;
        chk("lw_f_state", state, 0);
        tick(); #1;
        chk("lw_d_state", state, 1);
        tick(); #1;
        chk("lw_e_state", state, 2);
        for (int i = 0; i < 4; i++) begin
            tick();
            dmem_ack = (i == 3); #1;
            chk("lw_m_state", state, 3);
            chk("lw_m_dmem_req", dmem_req, 1);
            chk("lw_m_mem_write", mem_write, 0);
        end
        tick();
        dmem_ack = 1'b0; #1;
        chk("lw_wb_state", state, 4);
        chk("lw_wb_data", s_data_write, 1);
        chk("lw_wb_reg_write", reg_write, 1);
        tick(); #1;
        chk("lw_retire", retire_cnt, 2);
        chk("lw_back_fetch", state, 0);

        // BEQ taken, then not taken
        op = 6'h04;
        for (int z = 1; z >= 0; z--) begin
            tick(); #1;
            chk("beq_d_state", state, 1);
            tick();
            zero = z[0]; #1;
            chk("beq_e_state", state, 2);
            chk("beq_e_pc_write", pc_write, 1);
            chk("beq_e_npc", s_npc, z ? 1 : 0);
            chk("beq_e_reg_write", reg_write, 0);
            tick(); #1;
            chk("beq_fetch", state, 0);
        end
        chk("beq_retire", retire_cnt, 4);

        // Illegal opcode
        op = 6'h3F;
        tick(); #1;
        chk("ill_d_state", state, 1);
        tick(); #1;
        chk("ill_trap_state", state, 5);
        chk("ill_trap", trap, 1);
        chk("ill_cause", trap_cause, 2'b01);
        chk("ill_imem_req", imem_req, 0);
        tick(); #1;
        chk("ill_held", state, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        chk("ill_rst_state", state, 0);
        chk("ill_rst_trap", trap, 0);

        // imem timeout: 16 FETCH cycles without ack then TRAP
        imem_ack = 1'b0; op = 6'h00;
        for (int i = 0; i < 15; i++) begin
            tick(); #1;
            chk("to_fetch_state", state, 0);
        end
        tick(); #1;
        chk("to_trap_state", state, 5);
        chk("to_cause", trap_cause, 2'b10);
        rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        // ack on the 16th FETCH cycle still wins
        for (int i = 0; i < 15; i++) begin
            tick(); #1;
            chk("to2_fetch_state", state, 0);
        end
        imem_ack = 1'b1; #1;
        chk("to2_ir_write", ir_write, 1);
        tick(); #1;
        chk("to2_decode", state, 1);
        chk("to2_trap", trap, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // SW then JAL
        op = 6'h2B; dmem_ack = 1'b1; #1;
        chk("sw_f_state", state, 0);
        tick(); tick(); #1;
        chk("sw_e_state", state, 2);
        tick(); #1;
        chk("sw_m_state", state, 3);
        chk("sw_m_dmem_req", dmem_req, 1);
        chk("sw_m_mem_write", mem_write, 1);
        chk("sw_m_pc_write", pc_write, 1);
        chk("sw_m_reg_write", reg_write, 0);
        tick();
        op = 6'h03; #1;
        chk("sw_retire", retire_cnt, 1);
        tick(); tick(); tick(); #1;
        chk("jal_wb_state", state, 4);
        chk("jal_wb_num", s_num_write, 2);
        chk("jal_wb_data", s_data_write, 2);
        chk("jal_wb_npc", s_npc, 2);
        chk("jal_wb_reg_write", reg_write, 1);
        tick(); #1;
        chk("jal_retire", retire_cnt, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
